// File: rtl/regfile_fifo_ctrl_pkg.sv
// Shared types and constants for the register-file-backed FIFO controller.
// The controller sequences writes, reads and clears of an external 4-entry register file.
package regfile_fifo_ctrl_pkg;

  localparam int DEPTH = 4;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2,
    ST_FLUSH   = 2'd3
  } fifo_state_t;

endpackage

// File: rtl/regfile_fifo_ctrl.sv
// FIFO controller built around an external register file: it owns the pointers,
// the occupancy count and the flush sequence, while the register file holds the data.
module regfile_fifo_ctrl
  import regfile_fifo_ctrl_pkg::*;
#(
  parameter int W1 = 2,
  parameter int W2 = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_vld,
  input  logic [W2-1:0]        wr_data,
  output logic                 wr_rdy,
  input  logic                 rd_rdy,
  output logic                 rd_vld,
  output logic [W2-1:0]        rd_data,
  input  logic                 flush,
  output logic [W1-1:0]        rf_s,
  output logic                 rf_e,
  output logic [W2-1:0]        rf_d,
  output logic [W1*W1-1:0]     rf_clr,
  output logic [1:0]           rf_sel,
  input  logic [W2-1:0]        rf_o,
  output logic [W1:0]          count,
  output logic                 full,
  output logic                 empty
);

  localparam logic [W1-1:0] PTR_ONE  = W1'(1);
  localparam logic [W1:0]   CNT_ONE  = (W1 + 1)'(1);
  localparam logic [W1:0]   CNT_LAST = (W1 + 1)'(DEPTH - 1);

  fifo_state_t   state, next_state;
  logic [W1-1:0] wptr, rptr;
  logic [W1:0]   cnt;
  logic          push, pop;

  assign push = wr_vld & wr_rdy;
  assign pop  = rd_vld & rd_rdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_EMPTY;
    else      state <= next_state;
  end

  // Handshakes already fold in flush, so a flush cycle can never push or pop.
  always_comb begin
    next_state = state;
    wr_rdy     = 1'b0;
    rd_vld     = 1'b0;
    rf_clr     = '0;
    unique case (state)
      ST_EMPTY: begin
        wr_rdy = !flush;
        if (push) next_state = ST_PARTIAL;
      end
      ST_PARTIAL: begin
        wr_rdy = !flush;
        rd_vld = !flush;
        if (push && !pop && cnt == CNT_LAST)      next_state = ST_FULL;
        else if (pop && !push && cnt == CNT_ONE)  next_state = ST_EMPTY;
      end
      ST_FULL: begin
        rd_vld = !flush;
        if (pop) next_state = ST_PARTIAL;
      end
      ST_FLUSH: begin
        rf_clr     = '1;
        next_state = ST_EMPTY;
      end
      default: next_state = ST_EMPTY;
    endcase
    if (flush) next_state = ST_FLUSH;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (flush || state == ST_FLUSH) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
      if (push && !pop)      cnt <= cnt + CNT_ONE;
      else if (pop && !push) cnt <= cnt - CNT_ONE;
    end
  end

  assign rf_e    = push;
  assign rf_s    = wptr;
  assign rf_d    = wr_data;
  assign rf_sel  = 2'(rptr);
  assign rd_data = rf_o;
  assign count   = (state == ST_FLUSH) ? '0 : cnt;
  assign full    = (state == ST_FULL);
  assign empty   = (state == ST_EMPTY);

endmodule

// File: tb/tb_regfile_fifo_ctrl.sv
// Directed bench for regfile_fifo_ctrl with a behavioural 4-entry register file
// attached to the rf_* ports.
module tb_regfile_fifo_ctrl;

  logic       clk;
  logic       rst;
  logic       wr_vld;
  logic [7:0] wr_data;
  logic       wr_rdy;
  logic       rd_rdy;
  logic       rd_vld;
  logic [7:0] rd_data;
  logic       flush;
  logic [1:0] rf_s;
  logic       rf_e;
  logic [7:0] rf_d;
  logic [3:0] rf_clr;
  logic [1:0] rf_sel;
  logic [7:0] rf_o;
  logic [2:0] count;
  logic       full;
  logic       empty;

  int checks = 0;
  int errors = 0;

  logic [7:0] regs [4];

  regfile_fifo_ctrl #(.W1(2), .W2(8)) dut (
    .clk(clk), .rst(rst),
    .wr_vld(wr_vld), .wr_data(wr_data), .wr_rdy(wr_rdy),
    .rd_rdy(rd_rdy), .rd_vld(rd_vld), .rd_data(rd_data),
    .flush(flush),
    .rf_s(rf_s), .rf_e(rf_e), .rf_d(rf_d), .rf_clr(rf_clr),
    .rf_sel(rf_sel), .rf_o(rf_o),
    .count(count), .full(full), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file neighbour: clear wins over write, reset restores zeros.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (rf_clr[i])                      regs[i] <= '0;
        else if (rf_e && rf_s == 2'(i))     regs[i] <= rf_d;
      end
    end
  end
  assign rf_o = regs[rf_sel];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic wv, input logic [7:0] wd, input logic rr, input logic fl);
    wr_vld  = wv;
    wr_data = wd;
    rd_rdy  = rr;
    flush   = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] fill_data [4];

  initial begin
    fill_data[0] = 8'h11; fill_data[1] = 8'h22; fill_data[2] = 8'h33; fill_data[3] = 8'h44;
    rst = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

    $display("[TB] reset");
    checkOutput("rst_empty",  32'(empty),  32'd1);
    checkOutput("rst_full",   32'(full),   32'd0);
    checkOutput("rst_count",  32'(count),  32'd0);
    checkOutput("rst_wr_rdy", 32'(wr_rdy), 32'd1);
    checkOutput("rst_rd_vld", 32'(rd_vld), 32'd0);
    checkOutput("rst_rf_clr", 32'(rf_clr), 32'd0);
    checkOutput("rst_rf_e",   32'(rf_e),   32'd0);
    checkOutput("rst_rf_sel", 32'(rf_sel), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    $display("[TB] fill");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, fill_data[i], 1'b0, 1'b0);
      checkOutput($sformatf("fill_rf_s_%0d", i), 32'(rf_s), 32'(i));
      checkOutput($sformatf("fill_rf_e_%0d", i), 32'(rf_e), 32'd1);
      tick();
    end
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
    checkOutput("fill_full",   32'(full),   32'd1);
    checkOutput("fill_wr_rdy", 32'(wr_rdy), 32'd0);
    checkOutput("fill_rf_e5",  32'(rf_e),   32'd0);
    checkOutput("fill_count",  32'(count),  32'd4);
    tick();
    checkOutput("fill_count_after5", 32'(count), 32'd4);

    $display("[TB] drain");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput($sformatf("drain_rd_vld_%0d", i),  32'(rd_vld),  32'd1);
      checkOutput($sformatf("drain_rd_data_%0d", i), 32'(rd_data), 32'(fill_data[i]));
      tick();
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("drain_empty",  32'(empty),  32'd1);
    checkOutput("drain_rd_vld", 32'(rd_vld), 32'd0);
    checkOutput("drain_count",  32'(count),  32'd0);

    $display("[TB] wrap");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
      checkOutput($sformatf("wrap_rf_s_%0d", i), 32'(rf_s), 32'(i % 4));
      tick();
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput($sformatf("wrap_rf_sel_%0d", i),  32'(rf_sel),  32'(i % 4));
      checkOutput($sformatf("wrap_rd_data_%0d", i), 32'(rd_data), 32'hA0 + 32'(i));
      tick();
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("wrap_empty", 32'(empty), 32'd1);

    $display("[TB] simultaneous push/pop");
    applyStimulus(1'b1, 8'hC1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 8'hC2, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 8'hC3, 1'b1, 1'b0);
    checkOutput("sim_count_before", 32'(count),   32'd2);
    checkOutput("sim_rf_s_before",  32'(rf_s),    32'd0);
    checkOutput("sim_rf_sel_before",32'(rf_sel),  32'd2);
    checkOutput("sim_rd_data",      32'(rd_data), 32'hC1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("sim_count_after",  32'(count),   32'd2);
    checkOutput("sim_rf_s_after",   32'(rf_s),    32'd1);
    checkOutput("sim_rf_sel_after", 32'(rf_sel),  32'd3);
    checkOutput("sim_rd_data_next", 32'(rd_data), 32'hC2);
    applyStimulus(1'b1, 8'hC4, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("pre_flush_count", 32'(count), 32'd3);

    $display("[TB] flush");
    applyStimulus(1'b1, 8'hEE, 1'b0, 1'b1);
    checkOutput("flush_wr_rdy", 32'(wr_rdy), 32'd0);
    checkOutput("flush_rf_e",   32'(rf_e),   32'd0);
    checkOutput("flush_rd_vld", 32'(rd_vld), 32'd0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("flush_rf_clr", 32'(rf_clr), 32'hF);
    checkOutput("flush_count",  32'(count),  32'd0);
    checkOutput("flush_wr_rdy_st", 32'(wr_rdy), 32'd0);
    tick();
    checkOutput("post_flush_rf_clr", 32'(rf_clr), 32'd0);
    checkOutput("post_flush_empty",  32'(empty),  32'd1);
    checkOutput("post_flush_count",  32'(count),  32'd0);
    checkOutput("post_flush_rf_s",   32'(rf_s),   32'd0);
    checkOutput("post_flush_rf_sel", 32'(rf_sel), 32'd0);
    checkOutput("post_flush_wr_rdy", 32'(wr_rdy), 32'd1);
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("post_flush_rd_data", 32'(rd_data), 32'h77);
    checkOutput("post_flush_count1",  32'(count),   32'd1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("post_flush_drained", 32'(empty), 32'd1);

    $display("[TB] reset mid-operation");
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 8'h9A, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("mid_count_pre", 32'(count), 32'd2);
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_count",  32'(count),  32'd0);
    checkOutput("mid_rst_empty",  32'(empty),  32'd1);
    checkOutput("mid_rst_rf_clr", 32'(rf_clr), 32'd0);
    checkOutput("mid_rst_rf_s",   32'(rf_s),   32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    checkOutput("mid_post_rd_vld", 32'(rd_vld), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
